// File: rtl/cache_controle_lru.sv
// Four-line fully associative cache controller with write-back, write-allocate and true LRU.
// One request at a time; misses go out to memory through a simple req/ack handshake.
module cache_controle_lru (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_req,
  input  logic       i_write,
  input  logic [6:0] i_address,
  input  logic [4:0] i_blockIn,
  output logic       o_ready,
  output logic       o_done,
  output logic [4:0] o_blockOut,
  output logic       o_hit,
  output logic       o_mReq,
  output logic       o_cWriteM,
  output logic [6:0] o_mAddress,
  output logic [4:0] o_cBlockM,
  input  logic [4:0] i_mBlockC,
  input  logic       i_mAck
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LOOKUP    = 3'd1;
  localparam logic [2:0] WRITEBACK = 3'd2;
  localparam logic [2:0] FETCH     = 3'd3;
  localparam logic [2:0] DONE      = 3'd4;

  logic [2:0] r_state;
  logic       r_write;
  logic [6:0] r_addr;
  logic [4:0] r_dataIn;
  logic [1:0] r_line;
  logic       r_hit;
  logic [4:0] r_blockOut;
  logic [3:0] r_valid;
  logic [3:0] r_dirty;
  logic [6:0] r_tag [4];
  logic [4:0] r_data [4];
  logic [1:0] r_age [4];

  logic       w_hit;
  logic [1:0] w_hitIdx;
  logic       w_anyInvalid;
  logic [1:0] w_victim;

  // Victim is the lowest invalid line; only when the cache is full does LRU age decide.
  always_comb begin
    w_hit        = 1'b0;
    w_hitIdx     = 2'd0;
    w_anyInvalid = 1'b0;
    w_victim     = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (r_valid[i] && (r_tag[i] == r_addr)) begin
        w_hit    = 1'b1;
        w_hitIdx = 2'(i);
      end
      if (!r_valid[i]) begin
        w_anyInvalid = 1'b1;
        w_victim     = 2'(i);
      end
    end
    if (!w_anyInvalid) begin
      for (int i = 0; i < 4; i++) begin
        if (r_age[i] == 2'd3) w_victim = 2'(i);
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_write    <= 1'b0;
      r_addr     <= 7'd0;
      r_dataIn   <= 5'd0;
      r_line     <= 2'd0;
      r_hit      <= 1'b0;
      r_blockOut <= 5'd0;
      r_valid    <= 4'd0;
      r_dirty    <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        r_tag[i]  <= 7'd0;
        r_data[i] <= 5'd0;
        r_age[i]  <= 2'(i);
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (i_req) begin
            r_write  <= i_write;
            r_addr   <= i_address;
            r_dataIn <= i_blockIn;
            r_state  <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (w_hit) begin
            r_line     <= w_hitIdx;
            r_hit      <= 1'b1;
            r_blockOut <= r_write ? r_dataIn : r_data[w_hitIdx];
            if (r_write) begin
              r_data[w_hitIdx]  <= r_dataIn;
              r_dirty[w_hitIdx] <= 1'b1;
            end
            r_state <= DONE;
          end else begin
            r_line  <= w_victim;
            r_state <= (r_valid[w_victim] && r_dirty[w_victim]) ? WRITEBACK : FETCH;
          end
        end
        WRITEBACK: begin
          if (i_mAck) begin
            r_dirty[r_line] <= 1'b0;
            r_state         <= FETCH;
          end
        end
        FETCH: begin
          // Write-allocate: the fetched block is overwritten by the request data on the same edge.
          if (i_mAck) begin
            r_tag[r_line]   <= r_addr;
            r_valid[r_line] <= 1'b1;
            r_data[r_line]  <= r_write ? r_dataIn : i_mBlockC;
            r_dirty[r_line] <= r_write;
            r_hit           <= 1'b0;
            r_blockOut      <= r_write ? r_dataIn : i_mBlockC;
            r_state         <= DONE;
          end
        end
        DONE: begin
          for (int i = 0; i < 4; i++) begin
            if (2'(i) == r_line) r_age[i] <= 2'd0;
            else if (r_age[i] < r_age[r_line]) r_age[i] <= r_age[i] + 2'd1;
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_ready    = (r_state == IDLE);
  assign o_done     = (r_state == DONE);
  assign o_hit      = r_hit;
  assign o_blockOut = r_blockOut;
  assign o_mReq     = (r_state == WRITEBACK) || (r_state == FETCH);
  assign o_cWriteM  = (r_state == WRITEBACK);
  assign o_mAddress = (r_state == WRITEBACK) ? r_tag[r_line] :
                      (r_state == FETCH)     ? r_addr        : 7'd0;
  assign o_cBlockM  = (r_state == WRITEBACK) ? r_data[r_line] : 5'd0;

endmodule
